// File: rtl/ws2812_frame_sequencer.sv
// Frame scheduler for ws2812_rgb_controller: answers command/pixel requests, streams
// num_pixels words from a synchronous pixel RAM and closes every frame with a latch.
module ws2812_frame_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              repeat_mode,
  input  logic [ADDR_W:0]   num_pixels,
  output logic              busy,
  output logic              frame_done,
  output logic              pix_re,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  input  logic              cmd_request,
  input  logic              data_request,
  output logic [1:0]        command,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_FILL      = 3'd2;
  localparam logic [2:0] S_ARMED     = 3'd3;
  localparam logic [2:0] S_STREAM    = 3'd4;
  localparam logic [2:0] S_LATCH     = 3'd5;
  localparam logic [2:0] S_RESETTING = 3'd6;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  localparam logic [ADDR_W:0] MAX_PIX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_PIX = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] NO_PIX  = '0;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [ADDR_W:0]   n_reg, n_next;
  logic [23:0]       staged_reg;
  logic [1:0]        refill_reg;
  logic [1:0]        command_reg, command_next;
  logic              pix_re_reg, pix_re_next;
  logic [ADDR_W-1:0] pix_addr_reg, pix_addr_next;

  logic              refill_start;
  logic              load_frame;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   n_clamped;

  assign cnt_inc   = cnt_reg + ONE_PIX;
  assign n_clamped = (num_pixels > MAX_PIX) ? MAX_PIX : num_pixels;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    n_next       = n_reg;
    refill_start = 1'b0;
    load_frame   = 1'b0;
    frame_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) load_frame = 1'b1;
      end
      S_LOAD:  state_next = S_FILL;
      S_FILL:  state_next = S_ARMED;
      S_ARMED: begin
        // Pixel 0 leaves on the TX fetch, so pixel 1 must be fetched right away.
        if (cmd_request) begin
          cnt_next     = ONE_PIX;
          state_next   = S_STREAM;
          refill_start = (n_reg > ONE_PIX);
        end
      end
      S_STREAM: begin
        if (data_request) begin
          if (cnt_reg < n_reg) begin
            cnt_next     = cnt_inc;
            refill_start = (cnt_inc < n_reg);
          end else begin
            state_next = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        if (cmd_request) state_next = S_RESETTING;
      end
      S_RESETTING: begin
        if (cmd_request) begin
          frame_done = 1'b1;
          if (repeat_mode) load_frame = 1'b1;
          else             state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (load_frame) begin
      n_next     = n_clamped;
      cnt_next   = NO_PIX;
      state_next = (n_clamped == NO_PIX) ? S_LATCH : S_LOAD;
    end
  end

  // Outputs are registered from the next state so they change the cycle after an event.
  always_comb begin
    command_next = CMD_IDLE;
    case (state_next)
      S_ARMED:  command_next = CMD_TX;
      S_STREAM: command_next = (cnt_next < n_next) ? CMD_TX : CMD_IDLE;
      S_LATCH:  command_next = CMD_RESET;
      default:  command_next = CMD_IDLE;
    endcase
    pix_re_next   = (state_next == S_LOAD) || refill_start;
    pix_addr_next = refill_start ? cnt_next[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      n_reg        <= '0;
      staged_reg   <= '0;
      refill_reg   <= '0;
      command_reg  <= CMD_IDLE;
      pix_re_reg   <= 1'b0;
      pix_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      n_reg        <= n_next;
      refill_reg   <= {refill_reg[0], refill_start};
      command_reg  <= command_next;
      pix_re_reg   <= pix_re_next;
      pix_addr_reg <= pix_addr_next;
      if ((state_reg == S_FILL) || refill_reg[1]) staged_reg <= pix_data;
    end
  end

  assign busy     = (state_reg != S_IDLE);
  assign command  = command_reg;
  assign pix_re   = pix_re_reg;
  assign pix_addr = pix_addr_reg;
  assign r        = staged_reg[23:16];
  assign g        = staged_reg[15:8];
  assign b        = staged_reg[7:0];

endmodule
